// File: rtl/intpol2_d4_out_buffer_pkg.sv
// Shared defaults and helpers for the interpolator output buffer.
package intpol2_D4_pkg;

  localparam int DATAPATH_WIDTH_DEF = 32;
  localparam int FRAME_LEN_W_DEF    = 16;

  // Occupancy needs one extra bit so that "completely full" is representable.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/intpol2_d4_out_buffer_fifo_mem.sv
// Register-array storage for the output FIFO: one write port, asynchronous read port.
module intpol2_D4_fifo_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read keeps the head sample visible one cycle after it is written.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/intpol2_d4_out_buffer.sv
// Output buffer of the quadratic interpolator: FWFT FIFO with framed valid/ready output.
// Optional macro INTPOL2_D4_OUTBUF_DROPCNT_EN adds a saturating drop counter output (drop_cnt).
module intpol2_d4_out_buffer
  import intpol2_D4_pkg::*;
#(
  parameter int DATAPATH_WIDTH = DATAPATH_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 16,
  parameter int AF_MARGIN      = 2,
  parameter int FRAME_LEN_W    = FRAME_LEN_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                wr_en,
  input  logic [DATAPATH_WIDTH-1:0]           data_in,
  input  logic [FRAME_LEN_W-1:0]              frame_len,
  output logic [DATAPATH_WIDTH-1:0]           m_tdata,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic                                m_tlast,
  output logic                                almost_full,
  output logic                                full,
  output logic                                overflow,
`ifdef INTPOL2_D4_OUTBUF_DROPCNT_EN
  output logic [15:0]                         drop_cnt,
`endif
  output logic [level_width(FIFO_DEPTH)-1:0]  level
);

  localparam int LEVEL_W = level_width(FIFO_DEPTH);
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] DEPTH_LVL = LEVEL_W'(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] AF_LVL    = LEVEL_W'(FIFO_DEPTH - AF_MARGIN);

  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]        level_q, level_d;
  logic [FRAME_LEN_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                      overflow_q, overflow_d;
  logic                      pop, push, drop, last_hit;
  logic [DATAPATH_WIDTH-1:0] rdata;

  assign m_tvalid = (level_q != '0);
  assign pop      = m_tvalid & m_tready;
  // A pop in the same cycle frees a slot, so a write while full is still accepted.
  assign push     = wr_en & ((level_q < DEPTH_LVL) | pop);
  assign drop     = wr_en & ~push;

  // frame_len of 0 or 1 means every sample closes a frame.
  assign last_hit = (frame_len <= FRAME_LEN_W'(1)) |
                    (frame_cnt_q == frame_len - FRAME_LEN_W'(1));
  assign m_tlast  = m_tvalid & last_hit;

  // Gating keeps the output at zero when nothing is queued (e.g. right after reset).
  assign m_tdata     = m_tvalid ? rdata : '0;
  assign full        = (level_q == DEPTH_LVL);
  assign almost_full = (level_q >= AF_LVL);
  assign overflow    = overflow_q;
  assign level       = level_q;

  intpol2_D4_fifo_mem #(
    .DW    (DATAPATH_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q | drop;

    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      frame_cnt_d = m_tlast ? '0 : frame_cnt_q + FRAME_LEN_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef INTPOL2_D4_OUTBUF_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_intpol2_d4_out_buffer.sv
// Directed bench for intpol2_d4_out_buffer with an in-order scoreboard of expected samples.
module tb_intpol2_d4_out_buffer;

  logic        clk = 1'b0;
  logic        rst, clear, wr_en, m_tready;
  logic [31:0] data_in;
  logic [15:0] frame_len;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, almost_full, full, overflow;
  logic [4:0]  level;
`ifdef INTPOL2_D4_OUTBUF_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          m_lvl    = 0;
  int          wcnt     = 0;
  int          m_drops  = 0;
  bit          m_ovf    = 1'b0;
  logic [31:0] last_pop = '0;

  intpol2_d4_out_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .frame_len   (frame_len),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .almost_full (almost_full),
    .full        (full),
    .overflow    (overflow),
`ifdef INTPOL2_D4_OUTBUF_DROPCNT_EN
    .drop_cnt    (drop_cnt),
`endif
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, update the model, return #1 after the edge.
  task automatic cycle();
    bit   pop_m, push_m;
    exp_t e;
    @(negedge clk);
    check("level", 32'(level), 32'(m_lvl));
    check("tvalid", 32'(m_tvalid), 32'(m_lvl != 0));
    check("full", 32'(full), 32'(m_lvl == 16));
    check("almost_full", 32'(almost_full), 32'(m_lvl >= 14));
    check("overflow", 32'(overflow), 32'(m_ovf));
    pop_m  = (m_lvl != 0) && m_tready;
    push_m = wr_en && ((m_lvl < 16) || pop_m);
    if (pop_m) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL sb_empty: observed pop of 0x%08h expected no pop", m_tdata);
      end else begin
        e = exp_q.pop_front();
        check("tdata", m_tdata, e.data);
        check("tlast", 32'(m_tlast), 32'(e.last));
        last_pop = m_tdata;
      end
    end
    if (push_m) begin
      e.data = data_in;
      e.last = (frame_len <= 1) || ((wcnt % int'(frame_len)) == int'(frame_len) - 1);
      exp_q.push_back(e);
      wcnt++;
    end else if (wr_en) begin
      m_ovf = 1'b1;
      m_drops++;
    end
    @(posedge clk);
    #1;
    if (rst || clear) begin
      m_lvl   = 0;
      wcnt    = 0;
      m_drops = 0;
      m_ovf   = 1'b0;
      exp_q.delete();
    end else begin
      m_lvl = m_lvl + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    end
  endtask

  task automatic write(input logic [31:0] d);
    wr_en   = 1'b1;
    data_in = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; data_in = '0; m_tready = 1'b0; frame_len = 16'd4;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_level", 32'(level), 32'd0);

    // Basic flow: each sample leaves one cycle after it arrives, tlast on 4th and 8th.
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) write(32'(i));
    repeat (2) cycle();

    // Backpressure fill, overflow on the 17th write, then drain.
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      write(32'h0000_0100 + 32'(i));
      check("af_fill", 32'(almost_full), 32'(i + 1 >= 14));
      check("full_fill", 32'(full), 32'(i + 1 == 16));
    end
    write(32'hBAD0_0017);
    check("ovf_set", 32'(overflow), 32'd1);
    check("level_after_drop", 32'(level), 32'd16);
    m_tready = 1'b1;
    repeat (16) cycle();
    check("drain_empty", 32'(m_tvalid), 32'd0);
    check("drain_last", last_pop, 32'h0000_010F);
    pulse_clear();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop.
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) write(32'h0000_0200 + 32'(i));
    m_tready = 1'b1;
    write(32'hDEAD_BEEF);
    check("simul_ovf", 32'(overflow), 32'd0);
    check("simul_level", 32'(level), 32'd16);
    repeat (16) cycle();
    check("simul_last", last_pop, 32'hDEAD_BEEF);

    // Clear mid-frame.
    pulse_clear();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) write(32'h0000_0300 + 32'(i));
    m_tready = 1'b1;
    repeat (2) cycle();
    m_tready = 1'b0;
    check("pre_clear_level", 32'(level), 32'd3);
    pulse_clear();
    check("clr_level", 32'(level), 32'd0);
    check("clr_tvalid", 32'(m_tvalid), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) write(32'h0000_0400 + 32'(i));
    repeat (2) cycle();

    // Reset mid-operation.
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) write(32'h0000_0500 + 32'(i));
    check("pre_rst_level", 32'(level), 32'd5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_rst_tlast", 32'(m_tlast), 32'd0);
    check("mid_rst_tdata", m_tdata, 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_af", 32'(almost_full), 32'd0);
    m_tready = 1'b1;
    write(32'h8000_0000);
    cycle();
    check("sign_kept", last_pop, 32'h8000_0000);

`ifdef INTPOL2_D4_OUTBUF_DROPCNT_EN
    pulse_clear();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) write(32'h0000_0600 + 32'(i));
    for (int i = 0; i < 3; i++) write(32'h0000_0700 + 32'(i));
    check("drop_cnt_3", 32'(drop_cnt), 32'(m_drops));
    check("drop_cnt_abs", 32'(drop_cnt), 32'd3);
    pulse_clear();
    check("drop_cnt_clr", 32'(drop_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/intpol2_d4_out_buffer.md
Name: intpol2_D4_out_buffer

Overview:
- Downstream stage of the quadratic interpolator datapath.
- Captures each saturated interpolated sample (datapath data_out) when the controller strobes it, and buffers it in a small FIFO.
- Presents samples on a valid/ready stream interface with frame delimiting (m_tlast).
- Raises almost_full so the controller can stall interpolation before data is lost.

Parameters:
- DATAPATH_WIDTH, 32, sample width; matches the datapath.
- FIFO_DEPTH, 16, number of entries; power of 2, minimum 4.
- AF_MARGIN, 2, almost_full asserts when level >= FIFO_DEPTH-AF_MARGIN.
- FRAME_LEN_W, 16, width of frame_len and the frame counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- clear  in  1  synchronous flush: empties FIFO, zeroes frame counter, clears overflow
- wr_en  in  1  one-cycle strobe: data_in is a valid interpolated sample
- data_in  in  DATAPATH_WIDTH  signed sample from the datapath
- frame_len  in  FRAME_LEN_W  samples per frame; quasi-static, only changed while clear=1 or the FIFO is idle
- m_tdata  out  DATAPATH_WIDTH  head sample
- m_tvalid  out  1  FIFO not empty
- m_tready  in  1  consumer accepts
- m_tlast  out  1  head is the last sample of a frame
- almost_full  out  1  backpressure to the controller
- full  out  1  level == FIFO_DEPTH
- overflow  out  1  sticky: a write was dropped
- level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=1 at a clk edge): pointers=0, level=0, frame_cnt=0, overflow=0. Outputs: m_tvalid=0, m_tlast=0, full=0, almost_full=0, m_tdata=0.
- rst and clear are identical in effect except that storage contents are don't-care; rst has priority.
- pop = m_tvalid & m_tready.
- push = wr_en & (level < FIFO_DEPTH | pop).
  - When full, a simultaneous pop frees a slot, so the write is accepted.
- wr_en & ~push: sample dropped, overflow<=1. Overflow stays set until rst/clear.
- First-word fall-through: a sample written at edge t is visible on m_tdata with m_tvalid=1 after edge t; latency 1 cycle.
  - m_tdata = mem[rd_ptr], read combinationally from the register array.
  - m_tdata is held stable while m_tvalid & ~m_tready.
- Pointers wrap modulo FIFO_DEPTH.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- full = (level == FIFO_DEPTH); almost_full = (level >= FIFO_DEPTH-AF_MARGIN). Both are combinational from registered level.
- Frame counter counts popped samples.
  - m_tlast = m_tvalid & (frame_cnt == frame_len-1).
  - frame_len of 0 or 1 gives m_tlast on every sample.
  - On pop: frame_cnt <= m_tlast ? 0 : frame_cnt+1.
- No internal FSM beyond the counters. Stream states are EMPTY (level=0), PARTIAL, FULL, with transitions driven only by push/pop.
- Reset or clear mid-frame: the partial frame is discarded and the next accepted sample starts a new frame.

Optional Feature:
- Macro: INTPOL2_D4_OUTBUF_DROPCNT_EN
- Defined: adds output drop_cnt [15:0], a saturating count of dropped writes (stops at 16'hFFFF), zeroed by rst/clear.
- Undefined: port and counter are absent; only sticky overflow reports loss.

Decomposition:
- Package intpol2_D4_pkg holds:
  - DATAPATH_WIDTH default
  - the level-width function ($clog2(depth)+1)
  - FRAME_LEN_W default
- Sub-module intpol2_D4_fifo_mem: storage array with write port (we, waddr, wdata) and async read (raddr, rdata).
- Pointer, level, frame and flag logic stay in the top module.

Test Plan:
- Basic flow: frame_len=4, m_tready=1, write 0x0000_0001..0x0000_0008 on consecutive cycles.
  - Each appears one cycle later in order.
  - m_tlast on the 4th (0x4) and 8th (0x8) samples.
  - level never exceeds 1.
- Backpressure and fill: m_tready=0, write 16 samples.
  - almost_full asserts at level 14 and full at 16.
  - A 17th write sets overflow=1 and the sample is dropped.
  - Then m_tready=1 drains exactly the 16 original samples.
- Full with simultaneous push/pop: at level 16, assert wr_en with 0xDEAD_BEEF and m_tready=1 in the same cycle.
  - overflow stays 0, level stays 16.
  - 0xDEAD_BEEF is the last sample drained.
- Clear mid-frame: frame_len=4, pop 2 samples, pulse clear with 3 queued.
  - Next cycle: level=0, m_tvalid=0, overflow=0.
  - After a new write, m_tlast appears on the 4th subsequent sample.
- Reset mid-operation: rst=1 while level=5 and m_tvalid=1.
  - After the edge all outputs are zero.
  - A write of 0x8000_0000 after reset emerges unchanged (sign preserved).
- Optional feature (build with INTPOL2_D4_OUTBUF_DROPCNT_EN): with the FIFO full and m_tready=0, issue 3 writes.
  - drop_cnt=3.
  - After clear, drop_cnt=0.
